hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: cycles of continuous data-memory wait before mem_timeout asserts; legal range 1..255.
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port nrst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port de_valid  in  1  DE holds a real instruction.
REQ-005 SHALL have port de_is_branch  in  1  DE instruction is a branch compared in DE.
REQ-006 SHALL have ports decoded_rs1, decoded_rs2  in  5 each  DE source registers.
REQ-007 SHALL have port de_dep_check  in  2  bit0/bit1 = DE reads rs1/rs2.
REQ-008 SHALL have ports ex_rs1, ex_rs2  in  5 each, and ex_dep_check  in  2  EX source registers and their read flags.
REQ-009 SHALL have ports ex_rd, m1_rd  in  5 each; ex_wb_src, m1_wb_src  in  3 each; ex_mem_op, m1_mem_op  in  5 each  producer descriptors.
REQ-010 SHALL have port branch_taken  in  1  DE branch resolved taken this cycle.
REQ-011 SHALL have port dmem_ready  in  1  data memory accepts or completes the M1 access.
REQ-012 SHALL have outputs stall_if, stall_de, stall_ex  out  1 each  hold the stage register.
REQ-013 SHALL have outputs bubble_ex, bubble_m1  out  1 each  load a NOP into the stage register.
REQ-014 SHALL have outputs freeze  out  1  hold every stage; flush_if  out  1  kill the IF instruction.
REQ-015 SHALL have outputs stalled  out  1  OR of all stall/freeze outputs, consumed by the forwarding unit.
REQ-016 SHALL have outputs mem_timeout  out  1  sticky error; stall_cycles  out  32  performance counter.

Function
REQ-017 Producer P SHALL write register r when P_wb_src[2]=1, P_rd=r and r!=0; P is a load when P_mem_op[4:3]=MEM_READ.
REQ-018 ALU load-use: an M1 load writes a register that EX reads (per ex_dep_check) -> SHALL assert stall_if, stall_de, stall_ex and bubble_m1 in the same cycle, combinationally.
REQ-019 Branch hazard: de_valid, de_is_branch, and an EX or M1 instruction that is a load writing a register DE reads -> SHALL assert stall_if, stall_de and bubble_ex.
REQ-020 A load in EX with a dependent branch in DE SHALL produce exactly 2 stall cycles; a load in M1 SHALL produce exactly 1.
REQ-021 Memory wait: M1 load or store with dmem_ready=0 -> SHALL assert freeze and the stage stalls, with no bubble outputs; freeze has priority over all hazard outputs.
REQ-022 flush_if SHALL equal branch_taken AND NOT(any stall or freeze); a stalled branch is not resolved.
REQ-023 The FSM SHALL have states RUN, LOAD_STALL and MEM_WAIT, with next state evaluated every cycle:
  - RUN->MEM_WAIT on the memory-wait condition; RUN->LOAD_STALL on the REQ-018/019 condition.
  - LOAD_STALL->RUN when no hazard remains.
  - MEM_WAIT->RUN on dmem_ready=1, or ->LOAD_STALL when ready and a hazard is present.
REQ-024 In MEM_WAIT an 8-bit wait counter SHALL increment each cycle; it SHALL clear on exit and saturate at 255.
REQ-025 mem_timeout SHALL rise the cycle after the wait counter reaches MEM_TIMEOUT and SHALL hold until reset.
REQ-026 stall_cycles SHALL increment by 1 in every cycle where stalled=1, saturating at 32'hFFFF_FFFF.
REQ-027 Simultaneous rs1 and rs2 hazards on the same producer SHALL produce one stall episode, not two.
REQ-028 With de_valid=0, branch hazards SHALL be ignored.

Reset
REQ-029 While nrst=0 at a clock edge: state SHALL be RUN, wait counter 0, mem_timeout 0, stall_cycles 0.
REQ-030 Combinational outputs SHALL depend only on inputs and state, so in reset with quiescent inputs all stall, bubble, freeze and flush outputs are 0.
REQ-031 Reset asserted mid-stall SHALL abandon the episode without incrementing stall_cycles in that cycle.

Structure
REQ-032 WB_* source codes, MEM_READ and the FSM state enum SHALL live in the shared pipeline package.
REQ-033 One sub-module, hazard_match, SHALL compare a 5-bit source plus read flag against a producer descriptor (x0 excluded); it SHALL be instantiated per source/producer pair.

Verification
REQ-034 Bench SHALL cover these directed scenarios:
  - lw x5 in M1 with add in EX reading x5 -> stall_if/de/ex=1 and bubble_m1=1 for 1 cycle; stall_cycles=1.
  - lw x5 in EX with beq x5,x6 in DE -> stall_if/de and bubble_ex for 2 cycles; flush_if=0 throughout; resolves on cycle 3.
  - M1 store with dmem_ready=0 for 4 cycles -> freeze=1 for 4 cycles, bubbles 0, stall_cycles=4, mem_timeout=0.
  - MEM_TIMEOUT=3 with dmem_ready=0 held -> mem_timeout rises on cycle 4 and stays 1 after ready returns until nrst=0.
  - lw x0 in M1 with EX reading x0 -> no stall; branch_taken=1 with no hazard -> flush_if=1 the same cycle.
  - nrst=0 during MEM_WAIT -> next cycle state RUN, counters 0, all outputs 0.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions: write-back source codes, memory-op classes
// and the hazard unit FSM state encoding.
package hazard_control_unit_pkg;

   // wb_src[2] set means the instruction writes rd
   localparam logic [2:0] WB_NONE = 3'b000;
   localparam logic [2:0] WB_ALU  = 3'b100;
   localparam logic [2:0] WB_MEM  = 3'b101;
   localparam logic [2:0] WB_PC4  = 3'b110;
   localparam logic [2:0] WB_CSR  = 3'b111;

   // Memory-op class lives in mem_op[4:3]
   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hcu_state_t;

endpackage

// File: rtl/hazard_match.sv
// Flags a read of src (when rd_en) that depends on a load producer
// writing the same non-zero register.
module hazard_match
   import hazard_control_unit_pkg::*;
(
   input  logic [4:0] src,
   input  logic       rd_en,
   input  logic [4:0] p_rd,
   input  logic [2:0] p_wb_src,
   input  logic [4:0] p_mem_op,
   output logic       load_hit
);

   logic unused_bits;
   assign unused_bits = ^{p_wb_src[1:0], p_mem_op[2:0]};

   assign load_hit = rd_en && p_wb_src[2] && (p_rd == src) && (src != '0)
                     && (p_mem_op[4:3] == MEM_READ);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use and branch-on-load stalls, data-memory
// wait freeze, wait timeout detection and a stall-cycle counter.
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        de_valid,
   input  logic        de_is_branch,
   input  logic [4:0]  decoded_rs1,
   input  logic [4:0]  decoded_rs2,
   input  logic [1:0]  de_dep_check,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [1:0]  ex_dep_check,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  m1_rd,
   input  logic [2:0]  ex_wb_src,
   input  logic [2:0]  m1_wb_src,
   input  logic [4:0]  ex_mem_op,
   input  logic [4:0]  m1_mem_op,
   input  logic        branch_taken,
   input  logic        dmem_ready,
   output logic        stall_if,
   output logic        stall_de,
   output logic        stall_ex,
   output logic        bubble_ex,
   output logic        bubble_m1,
   output logic        freeze,
   output logic        flush_if,
   output logic        stalled,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   logic       lu_rs1, lu_rs2, br_ex_rs1, br_ex_rs2, br_m1_rs1, br_m1_rs2;
   logic       load_use, branch_haz, hazard, mem_wait;
   hcu_state_t state, state_next;
   logic [7:0] wait_cnt, wait_cnt_next;

   hazard_match u_lu_rs1 (.src(ex_rs1), .rd_en(ex_dep_check[0]), .p_rd(m1_rd),
      .p_wb_src(m1_wb_src), .p_mem_op(m1_mem_op), .load_hit(lu_rs1));
   hazard_match u_lu_rs2 (.src(ex_rs2), .rd_en(ex_dep_check[1]), .p_rd(m1_rd),
      .p_wb_src(m1_wb_src), .p_mem_op(m1_mem_op), .load_hit(lu_rs2));
   hazard_match u_br_ex_rs1 (.src(decoded_rs1), .rd_en(de_dep_check[0]), .p_rd(ex_rd),
      .p_wb_src(ex_wb_src), .p_mem_op(ex_mem_op), .load_hit(br_ex_rs1));
   hazard_match u_br_ex_rs2 (.src(decoded_rs2), .rd_en(de_dep_check[1]), .p_rd(ex_rd),
      .p_wb_src(ex_wb_src), .p_mem_op(ex_mem_op), .load_hit(br_ex_rs2));
   hazard_match u_br_m1_rs1 (.src(decoded_rs1), .rd_en(de_dep_check[0]), .p_rd(m1_rd),
      .p_wb_src(m1_wb_src), .p_mem_op(m1_mem_op), .load_hit(br_m1_rs1));
   hazard_match u_br_m1_rs2 (.src(decoded_rs2), .rd_en(de_dep_check[1]), .p_rd(m1_rd),
      .p_wb_src(m1_wb_src), .p_mem_op(m1_mem_op), .load_hit(br_m1_rs2));

   assign load_use   = lu_rs1 | lu_rs2;
   assign branch_haz = de_valid & de_is_branch
                       & (br_ex_rs1 | br_ex_rs2 | br_m1_rs1 | br_m1_rs2);
   assign hazard     = load_use | branch_haz;
   assign mem_wait   = ((m1_mem_op[4:3] == MEM_READ) || (m1_mem_op[4:3] == MEM_WRITE))
                       && !dmem_ready;

   // A memory wait holds every stage, so it masks the hazard bubbles.
   always_comb begin
      stall_if  = 1'b0;
      stall_de  = 1'b0;
      stall_ex  = 1'b0;
      bubble_ex = 1'b0;
      bubble_m1 = 1'b0;
      freeze    = 1'b0;
      if (mem_wait) begin
         freeze   = 1'b1;
         stall_if = 1'b1;
         stall_de = 1'b1;
         stall_ex = 1'b1;
      end else begin
         if (load_use) begin
            stall_if  = 1'b1;
            stall_de  = 1'b1;
            stall_ex  = 1'b1;
            bubble_m1 = 1'b1;
         end
         if (branch_haz) begin
            stall_if  = 1'b1;
            stall_de  = 1'b1;
            bubble_ex = 1'b1;
         end
      end
      stalled  = stall_if | stall_de | stall_ex | freeze;
      flush_if = branch_taken & ~stalled;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN, LOAD_STALL: begin
            if (mem_wait)    state_next = MEM_WAIT;
            else if (hazard) state_next = LOAD_STALL;
            else             state_next = RUN;
         end
         MEM_WAIT: begin
            if (!mem_wait)   state_next = hazard ? LOAD_STALL : RUN;
         end
         default: state_next = RUN;
      endcase
      // Counter includes the entry cycle so it equals the number of wait cycles seen.
      wait_cnt_next = '0;
      if (state_next == MEM_WAIT)
         wait_cnt_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         mem_timeout  <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (wait_cnt_next == TIMEOUT_CNT)
            mem_timeout <= 1'b1;
         if (stalled && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: combinational vector table plus
// multi-cycle sequences for stall counts, memory wait, timeout and reset.
module tb_hazard_control_unit;
   import hazard_control_unit_pkg::*;

   localparam logic [4:0] LW  = 5'b01010;
   localparam logic [4:0] SW  = 5'b10010;
   localparam logic [4:0] NOP = 5'b00000;

   logic        clk = 1'b0;
   logic        nrst;
   logic        de_valid, de_is_branch, branch_taken, dmem_ready;
   logic [4:0]  decoded_rs1, decoded_rs2, ex_rs1, ex_rs2, ex_rd, m1_rd, ex_mem_op, m1_mem_op;
   logic [1:0]  de_dep_check, ex_dep_check;
   logic [2:0]  ex_wb_src, m1_wb_src;

   logic        stall_if, stall_de, stall_ex, bubble_ex, bubble_m1, freeze, flush_if, stalled;
   logic        mem_timeout;
   logic [31:0] stall_cycles;
   logic        t_stall_if, t_stall_de, t_stall_ex, t_bubble_ex, t_bubble_m1, t_freeze;
   logic        t_flush_if, t_stalled, t_mem_timeout;
   logic [31:0] t_stall_cycles;
   logic [6:0]  outs;

   int unsigned npass = 0;
   int unsigned ntotal = 0;

   always #5 clk = ~clk;

   assign outs = {stall_if, stall_de, stall_ex, bubble_ex, bubble_m1, freeze, flush_if};

   hazard_control_unit dut_a (
      .clk(clk), .nrst(nrst), .de_valid(de_valid), .de_is_branch(de_is_branch),
      .decoded_rs1(decoded_rs1), .decoded_rs2(decoded_rs2), .de_dep_check(de_dep_check),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_dep_check(ex_dep_check),
      .ex_rd(ex_rd), .m1_rd(m1_rd), .ex_wb_src(ex_wb_src), .m1_wb_src(m1_wb_src),
      .ex_mem_op(ex_mem_op), .m1_mem_op(m1_mem_op), .branch_taken(branch_taken),
      .dmem_ready(dmem_ready), .stall_if(stall_if), .stall_de(stall_de),
      .stall_ex(stall_ex), .bubble_ex(bubble_ex), .bubble_m1(bubble_m1),
      .freeze(freeze), .flush_if(flush_if), .stalled(stalled),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   hazard_control_unit #(.MEM_TIMEOUT(3)) dut_t (
      .clk(clk), .nrst(nrst), .de_valid(de_valid), .de_is_branch(de_is_branch),
      .decoded_rs1(decoded_rs1), .decoded_rs2(decoded_rs2), .de_dep_check(de_dep_check),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_dep_check(ex_dep_check),
      .ex_rd(ex_rd), .m1_rd(m1_rd), .ex_wb_src(ex_wb_src), .m1_wb_src(m1_wb_src),
      .ex_mem_op(ex_mem_op), .m1_mem_op(m1_mem_op), .branch_taken(branch_taken),
      .dmem_ready(dmem_ready), .stall_if(t_stall_if), .stall_de(t_stall_de),
      .stall_ex(t_stall_ex), .bubble_ex(t_bubble_ex), .bubble_m1(t_bubble_m1),
      .freeze(t_freeze), .flush_if(t_flush_if), .stalled(t_stalled),
      .mem_timeout(t_mem_timeout), .stall_cycles(t_stall_cycles)
   );

   typedef struct {
      string      name;
      logic       dv, br;
      logic [4:0] drs1, drs2;
      logic [1:0] ddep;
      logic [4:0] xrs1, xrs2;
      logic [1:0] xdep;
      logic [4:0] xrd;
      logic [2:0] xwb;
      logic [4:0] xmem;
      logic [4:0] mrd;
      logic [2:0] mwb;
      logic [4:0] mmem;
      logic       bt, rdy;
      logic [6:0] exp;   // {stall_if, stall_de, stall_ex, bubble_ex, bubble_m1, freeze, flush_if}
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic quiesce();
      de_valid = 0; de_is_branch = 0; branch_taken = 0; dmem_ready = 1;
      decoded_rs1 = 0; decoded_rs2 = 0; de_dep_check = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_dep_check = 0; ex_rd = 0; ex_wb_src = WB_NONE;
      ex_mem_op = NOP; m1_rd = 0; m1_wb_src = WB_NONE; m1_mem_op = NOP;
   endtask

   task automatic apply_vec(input vec_t v);
      de_valid = v.dv; de_is_branch = v.br; decoded_rs1 = v.drs1; decoded_rs2 = v.drs2;
      de_dep_check = v.ddep; ex_rs1 = v.xrs1; ex_rs2 = v.xrs2; ex_dep_check = v.xdep;
      ex_rd = v.xrd; ex_wb_src = v.xwb; ex_mem_op = v.xmem; m1_rd = v.mrd;
      m1_wb_src = v.mwb; m1_mem_op = v.mmem; branch_taken = v.bt; dmem_ready = v.rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      quiesce();
      nrst = 0;
      tick();
      tick();
      nrst = 1;
   endtask

   initial begin
      //           name            dv br drs1 drs2 dd  xrs1 xrs2 xd  xrd xwb     xmem mrd mwb     mmem bt rdy exp
      vecs[0]  = '{"idle",         0, 0, 0,   0,   0,  0,   0,   0,  0,  WB_NONE, NOP, 0,  WB_NONE, NOP, 0, 1, 7'b0000000};
      vecs[1]  = '{"lu_rs1",       0, 0, 0,   0,   0,  5,   0,   1,  0,  WB_NONE, NOP, 5,  WB_MEM,  LW,  0, 1, 7'b1110100};
      vecs[2]  = '{"lu_rs2",       0, 0, 0,   0,   0,  0,   5,   2,  0,  WB_NONE, NOP, 5,  WB_MEM,  LW,  0, 1, 7'b1110100};
      vecs[3]  = '{"lu_noread",    0, 0, 0,   0,   0,  5,   0,   0,  0,  WB_NONE, NOP, 5,  WB_MEM,  LW,  0, 1, 7'b0000000};
      vecs[4]  = '{"lu_aluprod",   0, 0, 0,   0,   0,  5,   0,   1,  0,  WB_NONE, NOP, 5,  WB_ALU,  NOP, 0, 1, 7'b0000000};
      vecs[5]  = '{"lu_x0",        0, 0, 0,   0,   0,  0,   0,   1,  0,  WB_NONE, NOP, 0,  WB_MEM,  LW,  0, 1, 7'b0000000};
      vecs[6]  = '{"lu_both",      0, 0, 0,   0,   0,  5,   5,   3,  0,  WB_NONE, NOP, 5,  WB_MEM,  LW,  0, 1, 7'b1110100};
      vecs[7]  = '{"br_ex",        1, 1, 5,   6,   1,  0,   0,   0,  5,  WB_MEM,  LW,  0,  WB_NONE, NOP, 0, 1, 7'b1101000};
      vecs[8]  = '{"br_invalid",   0, 1, 5,   6,   1,  0,   0,   0,  5,  WB_MEM,  LW,  0,  WB_NONE, NOP, 0, 1, 7'b0000000};
      vecs[9]  = '{"br_m1_rs2",    1, 1, 7,   5,   2,  0,   0,   0,  0,  WB_NONE, NOP, 5,  WB_MEM,  LW,  0, 1, 7'b1101000};
      vecs[10] = '{"nonbr_dep",    1, 0, 5,   0,   1,  0,   0,   0,  5,  WB_MEM,  LW,  0,  WB_NONE, NOP, 0, 1, 7'b0000000};
      vecs[11] = '{"flush",        1, 1, 5,   6,   3,  0,   0,   0,  0,  WB_NONE, NOP, 0,  WB_NONE, NOP, 1, 1, 7'b0000001};
      vecs[12] = '{"br_haz_taken", 1, 1, 5,   6,   1,  0,   0,   0,  5,  WB_MEM,  LW,  0,  WB_NONE, NOP, 1, 1, 7'b1101000};
      vecs[13] = '{"st_wait",      0, 0, 0,   0,   0,  0,   0,   0,  0,  WB_NONE, NOP, 0,  WB_NONE, SW,  0, 0, 7'b1110010};
      vecs[14] = '{"lu_wait",      0, 0, 0,   0,   0,  5,   0,   1,  0,  WB_NONE, NOP, 5,  WB_MEM,  LW,  0, 0, 7'b1110010};
      vecs[15] = '{"st_ready",     0, 0, 0,   0,   0,  0,   0,   0,  0,  WB_NONE, NOP, 0,  WB_NONE, SW,  0, 1, 7'b0000000};
      vecs[16] = '{"idle_nrdy",    0, 0, 0,   0,   0,  0,   0,   0,  0,  WB_NONE, NOP, 0,  WB_NONE, NOP, 0, 0, 7'b0000000};
      vecs[17] = '{"flush_frozen", 1, 1, 5,   6,   3,  0,   0,   0,  0,  WB_NONE, NOP, 0,  WB_NONE, SW,  1, 0, 7'b1110010};
      vecs[18] = '{"br_ex_alu",    1, 1, 5,   6,   1,  0,   0,   0,  5,  WB_ALU,  NOP, 0,  WB_NONE, NOP, 0, 1, 7'b0000000};

      // Reset state with quiescent inputs
      do_reset();
      quiesce();
      nrst = 0;
      @(negedge clk);
      check("rst_outs", 32'(outs), 32'd0);
      check("rst_stalled", 32'(stalled), 32'd0);
      tick();
      @(negedge clk);
      check("rst_cycles", stall_cycles, 32'd0);
      check("rst_timeout", 32'(mem_timeout), 32'd0);
      check("rst_state", 32'(dut_a.state), 32'(RUN));
      nrst = 1;

      foreach (vecs[i]) begin
         tick();
         apply_vec(vecs[i]);
         @(negedge clk);
         check({vecs[i].name, "_outs"}, 32'(outs), 32'(vecs[i].exp));
         check({vecs[i].name, "_stalled"}, 32'(stalled), 32'(|vecs[i].exp[6:1]));
      end

      // ALU load-use: one stall cycle
      do_reset();
      ex_rs1 = 5; ex_dep_check = 2'b01; m1_rd = 5; m1_wb_src = WB_MEM; m1_mem_op = LW;
      @(negedge clk);
      check("lu_seq_c1", 32'(outs), 32'(7'b1110100));
      tick();
      quiesce();
      @(negedge clk);
      check("lu_seq_c2", 32'(outs), 32'd0);
      check("lu_seq_cycles", stall_cycles, 32'd1);

      // Load in EX feeding a branch in DE: two stall cycles, resolves on third
      tick();
      de_valid = 1; de_is_branch = 1; decoded_rs1 = 5; decoded_rs2 = 6; de_dep_check = 2'b11;
      branch_taken = 1; ex_rd = 5; ex_wb_src = WB_MEM; ex_mem_op = LW;
      @(negedge clk);
      check("br_seq_c1", 32'(outs), 32'(7'b1101000));
      tick();
      ex_rd = 0; ex_wb_src = WB_NONE; ex_mem_op = NOP;
      m1_rd = 5; m1_wb_src = WB_MEM; m1_mem_op = LW;
      @(negedge clk);
      check("br_seq_c2", 32'(outs), 32'(7'b1101000));
      tick();
      m1_rd = 0; m1_wb_src = WB_NONE; m1_mem_op = NOP;
      @(negedge clk);
      check("br_seq_c3", 32'(outs), 32'(7'b0000001));
      tick();
      quiesce();
      @(negedge clk);
      check("br_seq_cycles", stall_cycles, 32'd3);

      // Store waiting on memory for four cycles
      tick();
      m1_mem_op = SW; dmem_ready = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("st_seq_c%0d", c), 32'(outs), 32'(7'b1110010));
         tick();
      end
      quiesce();
      @(negedge clk);
      check("st_seq_after", 32'(outs), 32'd0);
      check("st_seq_cycles", stall_cycles, 32'd7);
      check("st_seq_timeout", 32'(mem_timeout), 32'd0);

      // Reset while in MEM_WAIT abandons the episode
      tick();
      m1_mem_op = SW; dmem_ready = 0;
      tick();
      tick();
      @(negedge clk);
      check("mw_state", 32'(dut_a.state), 32'(MEM_WAIT));
      nrst = 0;
      tick();
      nrst = 1;
      quiesce();
      @(negedge clk);
      check("mw_rst_state", 32'(dut_a.state), 32'(RUN));
      check("mw_rst_wait", 32'(dut_a.wait_cnt), 32'd0);
      check("mw_rst_cycles", stall_cycles, 32'd0);
      check("mw_rst_timeout", 32'(mem_timeout), 32'd0);
      check("mw_rst_t_timeout", 32'(t_mem_timeout), 32'd0);
      check("mw_rst_outs", 32'(outs), 32'd0);

      // Timeout with MEM_TIMEOUT=3: rises on the fourth wait cycle, sticky
      tick();
      m1_mem_op = SW; dmem_ready = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("to_c%0d", c), 32'(t_mem_timeout), (c == 4) ? 32'd1 : 32'd0);
         tick();
      end
      quiesce();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check($sformatf("to_hold%0d", c), 32'(t_mem_timeout), 32'd1);
         tick();
      end
      nrst = 0;
      tick();
      nrst = 1;
      @(negedge clk);
      check("to_rst", 32'(t_mem_timeout), 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
